// File: rtl/goldschmidt_pkg.sv
// Shared definitions for the Goldschmidt divider and its operand pre-normaliser.
package goldschmidt_pkg;

    // Pre-normaliser control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } prenorm_state_t;

    // Default fixed-point datapath width, Q2.(GS_WIDTH-2)
    localparam int GS_WIDTH  = 29;
    localparam int FRAC_BITS = GS_WIDTH - 2;

    // Initial reciprocal estimate 0.75 in Q2.FRAC_BITS, shared with the divider
    localparam logic [GS_WIDTH-1:0] K0 = GS_WIDTH'(3) << (FRAC_BITS - 2);

endpackage

// File: rtl/norm_shifter.sv
// One operand lane: load register, one-bit-per-cycle left shifter and
// shift counter. An operand is done once its MSB of fraction (bit WIDTH-3)
// is set, or when it is zero, so it never shifts into the integer bits.
module norm_shifter #(
    parameter int WIDTH = 29,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic [SHW-1:0]   count,
    output logic             done
);

    assign done = value[WIDTH-3] | (value == '0);

    // Load on acceptance, then shift left until normalised, counting shifts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_val;
            count <= '0;
        end else if (shift_en && !done) begin
            value <= {value[WIDTH-2:0], 1'b0};
            count <= count + SHW'(1);
        end
    end

endmodule

// File: rtl/goldschmidt_prenorm.sv
// Operand pre-normaliser ahead of goldschmidt_div. Converts raw unsigned
// dividend/divisor to Q2.(WIDTH-2), normalises each non-zero operand so its
// top fraction bit is set, and reports the binary scale between them so that
// dividend/divisor = (num_out/den_out) * 2^scale.
module goldschmidt_prenorm
    import goldschmidt_pkg::*;
#(
    parameter int IN_WIDTH = 24,
    parameter int WIDTH    = 29,
    parameter int SHW      = $clog2(IN_WIDTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] dividend,
    input  logic [IN_WIDTH-1:0] divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    num_out,
    output logic [WIDTH-1:0]    den_out,
    output logic [SHW:0]        scale,
    output logic                div_by_zero,
    output logic                num_zero
);

    // Raw integer x lands as x / 2^IN_WIDTH in Q2.(WIDTH-2)
    localparam int PAD = WIDTH - 2 - IN_WIDTH;

    prenorm_state_t     state;
    logic               load;
    logic               shift_en;
    logic               done_n;
    logic               done_d;
    logic [SHW-1:0]     cnt_n;
    logic [SHW-1:0]     cnt_d;
    logic [WIDTH-1:0]   load_n;
    logic [WIDTH-1:0]   load_d;

    assign load     = (state == IDLE) && in_valid;
    assign shift_en = (state == NORM);
    assign load_n   = WIDTH'(dividend) << PAD;
    assign load_d   = WIDTH'(divisor) << PAD;

    norm_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_num (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .load_val (load_n),
        .value    (num_out),
        .count    (cnt_n),
        .done     (done_n)
    );

    norm_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_den (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .load_val (load_d),
        .value    (den_out),
        .count    (cnt_d),
        .done     (done_d)
    );

    // Counters only move in NORM, so the difference is constant through HOLD
    assign scale = {1'b0, cnt_d} - {1'b0, cnt_n};

    // Control FSM with registered handshake outputs and operand-zero flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            num_zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state       <= NORM;
                        in_ready    <= 1'b0;
                        div_by_zero <= (divisor == '0);
                        num_zero    <= (dividend == '0);
                    end
                end
                NORM: begin
                    if (done_n && done_d) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_goldschmidt_prenorm.sv
// Directed bench for goldschmidt_prenorm with hand-computed expectations.
module tb_goldschmidt_prenorm;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] dividend;
    logic [23:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [28:0] num_out;
    logic [28:0] den_out;
    logic [5:0]  scale;
    logic        div_by_zero;
    logic        num_zero;

    int n_checks = 0;
    int n_errors = 0;

    goldschmidt_prenorm #(.IN_WIDTH(24), .WIDTH(29)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .num_out     (num_out),
        .den_out     (den_out),
        .scale       (scale),
        .div_by_zero (div_by_zero),
        .num_zero    (num_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic longint sc();
        return longint'($signed(scale));
    endfunction

    // Present one job for a single edge (edge 0), then count edges until out_valid
    task automatic start_job(input logic [23:0] dd, input logic [23:0] dv);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready before job", in_ready, 1);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready after accept", in_ready, 0);
    endtask

    task automatic wait_valid(input string tag, input int exp_edges);
        int edges;
        edges = 0;
        while (!out_valid && edges < 60) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, " latency"}, edges, exp_edges);
    endtask

    task automatic release_job(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, out_valid, 0);
        chk({tag, " in_ready back"}, in_ready, 1);
    endtask

    initial begin
        logic [28:0] hold_num;
        logic [28:0] hold_den;
        logic [5:0]  hold_scale;
        logic        ov [0:5];
        logic        ir [0:5];
        longint      sc_at [0:5];

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst num_out", num_out, 0);
        chk("rst den_out", den_out, 0);
        chk("rst scale", scale, 0);
        chk("rst flags", {div_by_zero, num_zero}, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: largest dividend over smallest divisor
        start_job(24'h800000, 24'h000001);
        wait_valid("t1", 24);
        chk("t1 num_out", num_out, 29'h0400_0000);
        chk("t1 den_out", den_out, 29'h0400_0000);
        chk("t1 scale", sc(), 23);
        chk("t1 flags", {div_by_zero, num_zero}, 0);
        release_job("t1");

        // 2: negative scale
        start_job(24'h000003, 24'h400000);
        wait_valid("t2", 23);
        chk("t2 num_out", num_out, 29'h0600_0000);
        chk("t2 den_out", den_out, 29'h0400_0000);
        chk("t2 scale", sc(), -21);
        chk("t2 flags", {div_by_zero, num_zero}, 0);
        release_job("t2");

        // 3: divide by zero
        start_job(24'h800000, 24'h000000);
        wait_valid("t3", 1);
        chk("t3 div_by_zero", div_by_zero, 1);
        chk("t3 num_zero", num_zero, 0);
        chk("t3 den_out", den_out, 0);
        chk("t3 num_out", num_out, 29'h0400_0000);
        chk("t3 scale", sc(), 0);
        release_job("t3");

        // zero dividend: done at once, flag only
        start_job(24'h000000, 24'h000100);
        wait_valid("tz", 16);
        chk("tz num_zero", num_zero, 1);
        chk("tz div_by_zero", div_by_zero, 0);
        chk("tz num_out", num_out, 0);
        chk("tz den_out", den_out, 29'h0400_0000);
        chk("tz scale", sc(), 15);
        release_job("tz");

        // 4: back-pressure in HOLD, in_valid ignored
        start_job(24'h800000, 24'h000001);
        wait_valid("t4", 24);
        hold_num   = num_out;
        hold_den   = den_out;
        hold_scale = scale;
        chk("t4 scale", sc(), 23);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                dividend = 24'h000005;
                divisor  = 24'h000007;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("t4 hold out_valid", out_valid, 1);
            chk("t4 hold in_ready", in_ready, 0);
            chk("t4 hold num", num_out, hold_num);
            chk("t4 hold den", den_out, hold_den);
            chk("t4 hold scale", scale, hold_scale);
        end
        in_valid = 1'b0;
        release_job("t4");

        // 5: asynchronous reset in the middle of NORM
        start_job(24'h800000, 24'h000001);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("t5 still norm", out_valid, 0);
        chk("t5 shifting", den_out != 29'h0000_0008, 1);
        reset = 1'b1;
        #1;
        chk("t5 rst in_ready", in_ready, 1);
        chk("t5 rst out_valid", out_valid, 0);
        chk("t5 rst num_out", num_out, 0);
        chk("t5 rst den_out", den_out, 0);
        chk("t5 rst scale", scale, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        start_job(24'h800000, 24'h000001);
        wait_valid("t5 rerun", 24);
        chk("t5 num_out", num_out, 29'h0400_0000);
        chk("t5 den_out", den_out, 29'h0400_0000);
        chk("t5 scale", sc(), 23);
        release_job("t5");

        // 6: streaming with both handshakes held high
        dividend  = 24'h800000;
        divisor   = 24'h800000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            ov[e]    = out_valid;
            ir[e]    = in_ready;
            sc_at[e] = sc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6 e0 in_ready", ir[0], 0);
        chk("t6 e0 out_valid", ov[0], 0);
        chk("t6 e1 out_valid", ov[1], 1);
        chk("t6 e1 scale", sc_at[1], 0);
        chk("t6 e2 out_valid", ov[2], 0);
        chk("t6 e2 in_ready", ir[2], 1);
        chk("t6 e3 in_ready", ir[3], 0);
        chk("t6 e3 out_valid", ov[3], 0);
        chk("t6 e4 out_valid", ov[4], 1);
        chk("t6 e4 scale", sc_at[4], 0);
        chk("t6 e5 out_valid", ov[5], 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
